ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Downstream counterpart of the main decoder. Accepts the decoded control bundle and register indices for the instruction in ID.
- Carries control bits through the ID/EX, EX/MEM and MEM/WB boundaries of the five-stage RV32IM pipeline.
- Detects load-use hazards, applies branch/jump flushes, and counts stall, flush and retire events for performance evaluation.

Parameters:
- CNT_W, 32, width of each performance counter.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_RegWrite, id_MemWrite, id_MemtoReg, id_Branch, id_Jump, id_ALUSrc  in  1 each  decoded controls for the ID instruction
- id_ALUOp  in  2  decoded ALU op class
- id_rs1, id_rs2, id_rd  in  REG_AW  ID register indices
- ex_taken  in  1  branch condition from EX, meaningful only when ex_Branch=1
- ex_valid, ex_RegWrite, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_Jump, ex_ALUSrc  out  1 each  EX-stage controls
- ex_ALUOp  out  2  EX-stage ALU op class
- ex_rd  out  REG_AW  EX destination register
- mem_valid, mem_RegWrite, mem_MemWrite, mem_MemtoReg  out  1 each  MEM-stage controls
- mem_rd  out  REG_AW  MEM destination register
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each  WB-stage controls
- wb_rd  out  REG_AW  WB destination register
- stall  out  1  combinational; hold PC and IF/ID this cycle
- flush  out  1  combinational; kill IF/ID contents this cycle
- redirect  out  1  combinational; equal to flush, selects the branch/jump target PC
- cnt_stall, cnt_flush, cnt_retire  out  CNT_W each  performance counters

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_/mem_/wb_ outputs, all *_rd outputs and all counters go to 0. The pipeline holds only bubbles after reset.
- Bubble: valid=0 and every control bit, ALUOp and rd equal 0. All stored controls are AND-gated with valid, so a bubble never writes a register or memory.
- Flush term: take = ex_valid & ((ex_Branch & ex_taken) | ex_Jump).
- Load-use term: lu = ex_valid & ex_MemtoReg & ex_RegWrite & (ex_rd≠0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Combinational outputs: flush = take; redirect = take; stall = lu & ~take.
- Flush has priority over stall. A flushed ID instruction is discarded, so a hazard on it is irrelevant.
- ID/EX register, each posedge:
  - If take or lu: load a bubble.
  - Else: load the id_* bundle with valid = id_valid.
- EX/MEM and MEM/WB registers advance unconditionally every cycle. There is no back-pressure from memory and the M-extension is single-cycle at this level.
- Latency: an ID instruction accepted at edge N appears on ex_* after edge N, on mem_* after N+1, and on wb_* after N+2.
- A load-use stall inserts exactly one bubble. On the next cycle the load is in MEM, lu deasserts and the held instruction proceeds; it uses MEM/WB forwarding, which is outside this block.
- A taken branch or jump in EX kills exactly the ID instruction (one bubble into EX). The IF-stage kill is performed by the fetch logic using the flush output.
- rd=x0: no load-use stall is raised. RegWrite still propagates; the register file ignores x0.
- Counters, each posedge:
  - cnt_stall +1 when stall=1.
  - cnt_flush +1 when flush=1.
  - cnt_retire +1 when wb_valid=1.
  - All counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-operation: immediate clear of all stages and counters, and the combinational stall/flush drop to 0 with it because ex_valid=0. After rst_n rises, the first id_valid instruction is accepted at the next edge.

Test Plan:
1. Reset then straight-line: `addi` (RegWrite=1, ALUSrc=1, ALUOp=00, rd=5) in ID at cycle 0 -> ex_RegWrite=1, ex_rd=5 after edge 1; wb_RegWrite=1, wb_rd=5 after edge 3; cnt_retire=1; stall and flush never asserted.
2. Load-use: `lw` with rd=6, then `add` with rs1=6 -> stall=1 for one cycle; ex_valid=0 for one cycle; `add` reaches EX one cycle late; cnt_stall=1.
3. Load to x0 followed by a reader of x0 -> stall stays 0 and no bubble is inserted.
4. Taken branch: ex_Branch=1, ex_taken=1 with an `add` in ID -> flush=1 and redirect=1 for one cycle; next ex_valid=0; cnt_flush=1. Repeat with ex_taken=0 -> flush stays 0.
5. Simultaneous: `jal` in EX together with a load-use pattern (EX `lw` is impossible, so use an EX load plus a jump bundle) -> flush=1, stall=0; priority holds.
6. Reset mid-stream: assert rst_n=0 mid-edge with three valid instructions in flight -> all outputs 0 immediately. Counter wrap: preload CNT_W=4, run 16 retires -> cnt_retire returns to 0.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-bit pipeline for the five-stage RV32IM core.
//
// Takes the decoded control bundle of the instruction in ID and carries it
// through the ID/EX, EX/MEM and MEM/WB boundaries. It also detects load-use
// hazards, applies branch/jump flushes and counts stall, flush and retire
// events.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid, id_*                  decoded bundle and register indices in ID
//   ex_taken                        branch condition resolved in EX
//   ex_*                            EX-stage controls (ID/EX register)
//   mem_*                           MEM-stage controls (EX/MEM register)
//   wb_*                            WB-stage controls (MEM/WB register)
//   stall                           hold PC and IF/ID this cycle
//   flush, redirect                 kill IF/ID and select the branch/jump target
//   cnt_stall, cnt_flush, cnt_retire  wrapping performance counters
module ctrl_pipe #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_RegWrite,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic              id_Branch,
  input  logic              id_Jump,
  input  logic              id_ALUSrc,
  input  logic [1:0]        id_ALUOp,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_taken,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_MemWrite,
  output logic              ex_MemtoReg,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic              ex_ALUSrc,
  output logic [1:0]        ex_ALUOp,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_RegWrite,
  output logic              mem_MemWrite,
  output logic              mem_MemtoReg,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              flush,
  output logic              redirect,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [CNT_W-1:0]  cnt_retire
);

  // ID/EX state
  logic              ex_valid_q,    ex_valid_d;
  logic              ex_RegWrite_q, ex_RegWrite_d;
  logic              ex_MemWrite_q, ex_MemWrite_d;
  logic              ex_MemtoReg_q, ex_MemtoReg_d;
  logic              ex_Branch_q,   ex_Branch_d;
  logic              ex_Jump_q,     ex_Jump_d;
  logic              ex_ALUSrc_q,   ex_ALUSrc_d;
  logic [1:0]        ex_ALUOp_q,    ex_ALUOp_d;
  logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;

  // EX/MEM state
  logic              mem_valid_q,    mem_valid_d;
  logic              mem_RegWrite_q, mem_RegWrite_d;
  logic              mem_MemWrite_q, mem_MemWrite_d;
  logic              mem_MemtoReg_q, mem_MemtoReg_d;
  logic [REG_AW-1:0] mem_rd_q,       mem_rd_d;

  // MEM/WB state
  logic              wb_valid_q,    wb_valid_d;
  logic              wb_RegWrite_q, wb_RegWrite_d;
  logic              wb_MemtoReg_q, wb_MemtoReg_d;
  logic [REG_AW-1:0] wb_rd_q,       wb_rd_d;

  // Performance counters
  logic [CNT_W-1:0]  cnt_stall_q,  cnt_stall_d;
  logic [CNT_W-1:0]  cnt_flush_q,  cnt_flush_d;
  logic [CNT_W-1:0]  cnt_retire_q, cnt_retire_d;

  logic take;
  logic lu;
  logic stall_w;

  // Hazard and flush detection
  always_comb begin
    take = ex_valid_q & ((ex_Branch_q & ex_taken) | ex_Jump_q);
    // A load writing x0 never produces a value anyone must wait for.
    lu   = ex_valid_q & ex_MemtoReg_q & ex_RegWrite_q & (ex_rd_q != '0) &
           id_valid & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
    // The flushed ID instruction is discarded, so its hazard does not matter.
    stall_w = lu & ~take;
  end

  // ID -> EX boundary
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_RegWrite_d = 1'b0;
    ex_MemWrite_d = 1'b0;
    ex_MemtoReg_d = 1'b0;
    ex_Branch_d   = 1'b0;
    ex_Jump_d     = 1'b0;
    ex_ALUSrc_d   = 1'b0;
    ex_ALUOp_d    = 2'b00;
    ex_rd_d       = '0;
    if (!(take | lu)) begin
      // Gating every field with valid keeps a bubble fully zero.
      ex_valid_d    = id_valid;
      ex_RegWrite_d = id_RegWrite & id_valid;
      ex_MemWrite_d = id_MemWrite & id_valid;
      ex_MemtoReg_d = id_MemtoReg & id_valid;
      ex_Branch_d   = id_Branch   & id_valid;
      ex_Jump_d     = id_Jump     & id_valid;
      ex_ALUSrc_d   = id_ALUSrc   & id_valid;
      ex_ALUOp_d    = id_ALUOp    & {2{id_valid}};
      ex_rd_d       = id_rd       & {REG_AW{id_valid}};
    end
  end

  // EX -> MEM boundary
  always_comb begin
    mem_valid_d    = ex_valid_q;
    mem_RegWrite_d = ex_RegWrite_q & ex_valid_q;
    mem_MemWrite_d = ex_MemWrite_q & ex_valid_q;
    mem_MemtoReg_d = ex_MemtoReg_q & ex_valid_q;
    mem_rd_d       = ex_rd_q & {REG_AW{ex_valid_q}};
  end

  // MEM -> WB boundary
  always_comb begin
    wb_valid_d    = mem_valid_q;
    wb_RegWrite_d = mem_RegWrite_q & mem_valid_q;
    wb_MemtoReg_d = mem_MemtoReg_q & mem_valid_q;
    wb_rd_d       = mem_rd_q & {REG_AW{mem_valid_q}};
  end

  // Counter next-state; wraps naturally at 2^CNT_W
  always_comb begin
    cnt_stall_d  = cnt_stall_q  + {{(CNT_W-1){1'b0}}, stall_w};
    cnt_flush_d  = cnt_flush_q  + {{(CNT_W-1){1'b0}}, take};
    cnt_retire_d = cnt_retire_q + {{(CNT_W-1){1'b0}}, wb_valid_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_RegWrite_q  <= 1'b0;
      ex_MemWrite_q  <= 1'b0;
      ex_MemtoReg_q  <= 1'b0;
      ex_Branch_q    <= 1'b0;
      ex_Jump_q      <= 1'b0;
      ex_ALUSrc_q    <= 1'b0;
      ex_ALUOp_q     <= 2'b00;
      ex_rd_q        <= '0;
      mem_valid_q    <= 1'b0;
      mem_RegWrite_q <= 1'b0;
      mem_MemWrite_q <= 1'b0;
      mem_MemtoReg_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_RegWrite_q  <= 1'b0;
      wb_MemtoReg_q  <= 1'b0;
      wb_rd_q        <= '0;
      cnt_stall_q    <= '0;
      cnt_flush_q    <= '0;
      cnt_retire_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_RegWrite_q  <= ex_RegWrite_d;
      ex_MemWrite_q  <= ex_MemWrite_d;
      ex_MemtoReg_q  <= ex_MemtoReg_d;
      ex_Branch_q    <= ex_Branch_d;
      ex_Jump_q      <= ex_Jump_d;
      ex_ALUSrc_q    <= ex_ALUSrc_d;
      ex_ALUOp_q     <= ex_ALUOp_d;
      ex_rd_q        <= ex_rd_d;
      mem_valid_q    <= mem_valid_d;
      mem_RegWrite_q <= mem_RegWrite_d;
      mem_MemWrite_q <= mem_MemWrite_d;
      mem_MemtoReg_q <= mem_MemtoReg_d;
      mem_rd_q       <= mem_rd_d;
      wb_valid_q     <= wb_valid_d;
      wb_RegWrite_q  <= wb_RegWrite_d;
      wb_MemtoReg_q  <= wb_MemtoReg_d;
      wb_rd_q        <= wb_rd_d;
      cnt_stall_q    <= cnt_stall_d;
      cnt_flush_q    <= cnt_flush_d;
      cnt_retire_q   <= cnt_retire_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_RegWrite  = ex_RegWrite_q;
  assign ex_MemWrite  = ex_MemWrite_q;
  assign ex_MemtoReg  = ex_MemtoReg_q;
  assign ex_Branch    = ex_Branch_q;
  assign ex_Jump      = ex_Jump_q;
  assign ex_ALUSrc    = ex_ALUSrc_q;
  assign ex_ALUOp     = ex_ALUOp_q;
  assign ex_rd        = ex_rd_q;
  assign mem_valid    = mem_valid_q;
  assign mem_RegWrite = mem_RegWrite_q;
  assign mem_MemWrite = mem_MemWrite_q;
  assign mem_MemtoReg = mem_MemtoReg_q;
  assign mem_rd       = mem_rd_q;
  assign wb_valid     = wb_valid_q;
  assign wb_RegWrite  = wb_RegWrite_q;
  assign wb_MemtoReg  = wb_MemtoReg_q;
  assign wb_rd        = wb_rd_q;
  assign stall        = stall_w;
  assign flush        = take;
  assign redirect     = take;
  assign cnt_stall    = cnt_stall_q;
  assign cnt_flush    = cnt_flush_q;
  assign cnt_retire   = cnt_retire_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;
  localparam int CW = 4;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_RegWrite, id_MemWrite, id_MemtoReg, id_Branch, id_Jump, id_ALUSrc;
  logic [1:0] id_ALUOp;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic ex_taken;
  logic ex_valid, ex_RegWrite, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_Jump, ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic mem_valid, mem_RegWrite, mem_MemWrite, mem_MemtoReg;
  logic wb_valid, wb_RegWrite, wb_MemtoReg;
  logic stall, flush, redirect;
  logic [CW-1:0] cnt_stall, cnt_flush, cnt_retire;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.CNT_W(CW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch), .id_Jump(id_Jump),
    .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch), .ex_Jump(ex_Jump),
    .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemWrite(mem_MemWrite),
    .mem_MemtoReg(mem_MemtoReg), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd),
    .stall(stall), .flush(flush), .redirect(redirect),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_retire(cnt_retire)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each stage slot holds the instruction's control word; a bubble is all-zero.
  typedef struct packed {
    logic v, rw, mw, m2r, br, j, als;
    logic [1:0] op;
    logic [AW-1:0] rd;
  } ins_t;

  ins_t m_ex = '0, m_mem = '0, m_wb = '0;
  int m_cs = 0, m_cf = 0, m_cr = 0;

  function automatic logic m_take();
    return m_ex.v && ((m_ex.br && ex_taken) || m_ex.j);
  endfunction

  function automatic logic m_lu();
    return m_ex.v && m_ex.m2r && m_ex.rw && m_ex.rd != 0 && id_valid &&
           (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
  endfunction

  function automatic ins_t id_word();
    ins_t w;
    w = '0;
    if (id_valid) begin
      w.v = 1; w.rw = id_RegWrite; w.mw = id_MemWrite; w.m2r = id_MemtoReg;
      w.br = id_Branch; w.j = id_Jump; w.als = id_ALUSrc; w.op = id_ALUOp; w.rd = id_rd;
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
      m_cs = 0; m_cf = 0; m_cr = 0;
    end else begin
      logic tk, l;
      tk = m_take();
      l  = m_lu();
      if (l && !tk) m_cs++;
      if (tk) m_cf++;
      if (m_wb.v) m_cr++;
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (tk || l) ? ins_t'(0) : id_word();
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("ex_valid",     ex_valid,     m_ex.v);
    chk("ex_RegWrite",  ex_RegWrite,  m_ex.rw);
    chk("ex_MemWrite",  ex_MemWrite,  m_ex.mw);
    chk("ex_MemtoReg",  ex_MemtoReg,  m_ex.m2r);
    chk("ex_Branch",    ex_Branch,    m_ex.br);
    chk("ex_Jump",      ex_Jump,      m_ex.j);
    chk("ex_ALUSrc",    ex_ALUSrc,    m_ex.als);
    chk("ex_ALUOp",     ex_ALUOp,     m_ex.op);
    chk("ex_rd",        ex_rd,        m_ex.rd);
    chk("mem_valid",    mem_valid,    m_mem.v);
    chk("mem_RegWrite", mem_RegWrite, m_mem.rw);
    chk("mem_MemWrite", mem_MemWrite, m_mem.mw);
    chk("mem_MemtoReg", mem_MemtoReg, m_mem.m2r);
    chk("mem_rd",       mem_rd,       m_mem.rd);
    chk("wb_valid",     wb_valid,     m_wb.v);
    chk("wb_RegWrite",  wb_RegWrite,  m_wb.rw);
    chk("wb_MemtoReg",  wb_MemtoReg,  m_wb.m2r);
    chk("wb_rd",        wb_rd,        m_wb.rd);
    chk("stall",        stall,        rst_n && m_lu() && !m_take());
    chk("flush",        flush,        rst_n && m_take());
    chk("redirect",     redirect,     rst_n && m_take());
    chk("cnt_stall",    cnt_stall,    m_cs % (1 << CW));
    chk("cnt_flush",    cnt_flush,    m_cf % (1 << CW));
    chk("cnt_retire",   cnt_retire,   m_cr % (1 << CW));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, rw, mw, m2r, br, j, als, input logic [1:0] op,
                       input logic [AW-1:0] r1, r2, rd);
    id_valid = v; id_RegWrite = rw; id_MemWrite = mw; id_MemtoReg = m2r;
    id_Branch = br; id_Jump = j; id_ALUSrc = als; id_ALUOp = op;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    ex_taken = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    cyc();
    cyc();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    cyc();
    // reset state
    #1;
    chk("rst ex_valid", ex_valid, 0);
    chk("rst cnt_retire", cnt_retire, 0);
    rst_n = 1;

    // 1: straight-line addi x5
    drive(1, 1, 0, 0, 0, 0, 1, 2'b00, 1, 0, 5);
    cyc();
    idle();
    #1;
    chk("t1 ex_RegWrite", ex_RegWrite, 1);
    chk("t1 ex_rd", ex_rd, 5);
    chk("t1 ex_ALUSrc", ex_ALUSrc, 1);
    cyc(); cyc();
    chk("t1 wb_RegWrite", wb_RegWrite, 1);
    chk("t1 wb_rd", wb_rd, 5);
    cyc();
    chk("t1 cnt_retire", cnt_retire, 1);
    chk("t1 cnt_stall", cnt_stall, 0);
    chk("t1 cnt_flush", cnt_flush, 0);

    // 2: lw x6 then add using x6
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 1, 2'b00, 2, 0, 6);
    cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 6, 7, 8);
    #1;
    chk("t2 stall", stall, 1);
    chk("t2 flush", flush, 0);
    cyc();
    #1;
    chk("t2 bubble ex_valid", ex_valid, 0);
    chk("t2 stall released", stall, 0);
    cyc();
    idle();
    #1;
    chk("t2 add ex_valid", ex_valid, 1);
    chk("t2 add ex_rd", ex_rd, 8);
    chk("t2 cnt_stall", cnt_stall, 1);

    // 3: load to x0, then reader of x0
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 1, 2'b00, 2, 0, 0);
    cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 0, 0, 9);
    #1;
    chk("t3 stall", stall, 0);
    cyc();
    idle();
    #1;
    chk("t3 ex_valid", ex_valid, 1);
    chk("t3 ex_rd", ex_rd, 9);
    chk("t3 cnt_stall", cnt_stall, 0);

    // 4: taken branch, then not-taken branch
    do_reset();
    drive(1, 0, 0, 0, 1, 0, 0, 2'b01, 1, 2, 0);
    cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 4, 5, 3);
    ex_taken = 1;
    #1;
    chk("t4 flush", flush, 1);
    chk("t4 redirect", redirect, 1);
    chk("t4 stall", stall, 0);
    cyc();
    idle();
    #1;
    chk("t4 ex_valid", ex_valid, 0);
    chk("t4 flush drop", flush, 0);
    chk("t4 cnt_flush", cnt_flush, 1);
    drive(1, 0, 0, 0, 1, 0, 0, 2'b01, 1, 2, 0);
    cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 4, 5, 3);
    ex_taken = 0;
    #1;
    chk("t4 nt flush", flush, 0);
    cyc();
    idle();
    #1;
    chk("t4 nt ex_valid", ex_valid, 1);
    chk("t4 nt ex_rd", ex_rd, 3);
    chk("t4 nt cnt_flush", cnt_flush, 1);

    // 5: EX load+jump bundle with a dependent ID instruction
    do_reset();
    drive(1, 1, 0, 1, 0, 1, 0, 2'b00, 0, 0, 6);
    cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 6, 0, 7);
    #1;
    chk("t5 flush", flush, 1);
    chk("t5 stall", stall, 0);
    cyc();
    idle();
    #1;
    chk("t5 ex_valid", ex_valid, 0);
    chk("t5 cnt_stall", cnt_stall, 0);
    chk("t5 cnt_flush", cnt_flush, 1);

    // 6: asynchronous reset with three instructions in flight
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, AW'(i));
      cyc();
    end
    #1;
    chk("t6 pre cnt_retire", cnt_retire, 1);
    chk("t6 pre wb_rd", wb_rd, 2);
    rst_n = 0;
    #1;
    chk("t6 ex_valid", ex_valid, 0);
    chk("t6 mem_valid", mem_valid, 0);
    chk("t6 wb_valid", wb_valid, 0);
    chk("t6 ex_rd", ex_rd, 0);
    chk("t6 wb_rd", wb_rd, 0);
    chk("t6 cnt_retire", cnt_retire, 0);
    chk("t6 stall", stall, 0);
    chk("t6 flush", flush, 0);
    cyc();
    rst_n = 1;
    drive(1, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 12);
    cyc();
    idle();
    #1;
    chk("t6 accept ex_valid", ex_valid, 1);
    chk("t6 accept ex_rd", ex_rd, 12);

    // counter wrap with a 4-bit counter: 16 retires
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc();
    idle();
    cyc(); cyc();
    chk("wrap cnt_retire 15", cnt_retire, 15);
    cyc();
    chk("wrap cnt_retire 0", cnt_retire, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
